// File: rtl/gpio_bus_pkg.sv
// Shared definitions for the GPIO bus master.
// Op codes, FSM states and GPIO register offsets.
package gpio_bus_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_POLL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    POLL_RD,
    POLL_WAIT,
    RESP
  } state_t;

  localparam logic [7:0] REG_DATA = 8'h0;
  localparam logic [7:0] REG_DIR  = 8'h4;
  localparam logic [7:0] REG_READ = 8'h8;

endpackage

// File: rtl/bus_master_down_counter.sv
// Loadable down counter with a zero flag.
// Saturates at zero; load wins over decrement.
module bus_master_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  assign zero = (count == '0);

  // count register: load, else decrement until zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/gpio_bus_master.sv
// Single-outstanding command bus master for GPIO registers.
// Supports write, read and masked poll with gap and attempt limit.
module gpio_bus_master
  import gpio_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  input  logic [CNT_WIDTH-1:0]  poll_limit,
  input  logic [7:0]            poll_gap,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  o_sel,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata
);

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] mask_q;

  logic                 accept;
  logic                 hit;
  logic                 att_last;
  logic                 gap_done;
  logic [CNT_WIDTH-1:0] att_load;

  assign accept = cmd_valid && cmd_ready;
  assign hit    = ((i_rdata ^ data_q) & mask_q) == '0;

  // attempts remaining after this read; limit 0 behaves as 1
  assign att_load = (poll_limit == '0) ? '0
                  : poll_limit - CNT_WIDTH'(1);

  bus_master_down_counter #(.WIDTH(CNT_WIDTH)) u_att (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (att_load),
    .dec      (state == POLL_RD),
    .zero     (att_last)
  );

  // gap counter loads gap-1 so POLL_WAIT lasts exactly poll_gap cycles
  bus_master_down_counter #(.WIDTH(8)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (state == POLL_RD),
    .load_val (poll_gap - 8'd1),
    .dec      (state == POLL_WAIT),
    .zero     (gap_done)
  );

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign o_sel     = (state == WRITE) || (state == READ)
                  || (state == POLL_RD);
  assign o_we      = (state == WRITE);
  assign o_addr    = addr_q;
  assign o_wdata   = data_q;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state decode
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          unique case (op_t'(cmd_op))
            OP_WRITE: state_next = WRITE;
            OP_READ:  state_next = READ;
            OP_POLL:  state_next = POLL_RD;
            OP_RSVD:  state_next = RESP;
          endcase
        end
      end
      WRITE:   state_next = RESP;
      READ:    state_next = RESP;
      POLL_RD: begin
        if (hit || att_last)     state_next = RESP;
        else if (poll_gap == '0) state_next = POLL_RD;
        else                     state_next = POLL_WAIT;
      end
      POLL_WAIT: if (gap_done) state_next = POLL_RD;
      RESP:      if (rsp_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // latch command fields on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else if (accept) begin
      addr_q <= cmd_addr;
      data_q <= cmd_data;
      mask_q <= cmd_mask;
    end
  end

  // response payload; held untouched while in RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      rsp_data <= '0;
      rsp_err  <= (op_t'(cmd_op) == OP_RSVD);
    end else if (state == READ) begin
      rsp_data <= i_rdata;
    end else if (state == POLL_RD) begin
      rsp_data <= i_rdata;
      rsp_err  <= !hit && att_last;
    end
  end

endmodule

// File: doc/gpio_bus_master.md
GPIO_BUS_MASTER -- requirements
Module: gpio_bus_master

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 4, bus address width; DATA_WIDTH, default 32, bus data width; CNT_WIDTH, default 16, poll-attempt counter width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_op  input  2  00 write, 01 read, 10 poll, 11 reserved.
REQ-007 cmd_addr  input  ADDR_WIDTH  target register offset.
REQ-008 cmd_data  input  DATA_WIDTH  write data, or poll expected value.
REQ-009 cmd_mask  input  DATA_WIDTH  poll compare mask; ignored for other ops.
REQ-010 poll_limit  input  CNT_WIDTH  maximum poll reads; static during a poll.
REQ-011 poll_gap  input  8  idle cycles between poll reads; static during a poll.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed.
REQ-014 rsp_data  output  DATA_WIDTH  read data, last poll data, or 0.
REQ-015 rsp_err  output  1  poll timeout or reserved op.
REQ-016 o_sel  output  1  bus chip select.
REQ-017 o_we  output  1  bus write enable.
REQ-018 o_addr  output  ADDR_WIDTH  bus address.
REQ-019 o_wdata  output  DATA_WIDTH  bus write data.
REQ-020 i_rdata  input  DATA_WIDTH  bus read data; valid combinationally while o_sel=1 and o_we=0.

Function
REQ-021 The FSM SHALL have states IDLE, WRITE, READ, POLL_RD, POLL_WAIT and RESP.
REQ-022 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1, and its fields are latched on that edge.
REQ-023 Accepted op 00 → WRITE, 01 → READ, 10 → POLL_RD (attempt count cleared), 11 → RESP with rsp_err=1 and rsp_data=0, with no bus cycle.
REQ-024 WRITE SHALL last exactly one cycle with o_sel=1, o_we=1 and the latched addr/data, then go to RESP with rsp_data=0 and rsp_err=0.
REQ-025 READ SHALL last exactly one cycle with o_sel=1 and o_we=0; i_rdata is captured at the end of that cycle into rsp_data; rsp_err=0; next state RESP.
REQ-026 POLL_RD SHALL issue one read cycle, capture i_rdata and increment the attempt count.
REQ-027 Poll completion SHALL be decided in that same cycle:
- (i_rdata & mask) == (data & mask) → RESP, rsp_err=0;
- else attempts == max(poll_limit,1) → RESP, rsp_err=1;
- else → POLL_WAIT.
REQ-028 POLL_WAIT SHALL hold for poll_gap cycles, then return to POLL_RD; poll_gap=0 goes straight back to POLL_RD on the next cycle.
REQ-029 Outside WRITE, READ and POLL_RD, o_sel and o_we SHALL be 0; o_addr and o_wdata are don't-care.
REQ-030 Bus outputs SHALL be decoded from registered state only, so they are glitch-free.
REQ-031 In RESP, rsp_valid SHALL be 1, with rsp_data and rsp_err held stable until rsp_ready=1; the state then returns to IDLE on that edge.
REQ-032 Latency from accept to rsp_valid SHALL be:
- write/read: 2 cycles;
- reserved op: 1 cycle;
- poll matching on read N: 1 + N + (N-1)·poll_gap cycles.
REQ-033 Exactly one command SHALL be outstanding at a time; a new command is accepted no earlier than the cycle after the response handshake.

Reset
REQ-034 On reset=1, the block SHALL immediately and asynchronously force: state IDLE, o_sel=0, o_we=0, rsp_valid=0, rsp_err=0, rsp_data=0, o_addr=0, o_wdata=0, counters 0.
REQ-035 A reset during any state SHALL abort the command and drop any pending response; no bus cycle is issued after reset deasserts until a new command is accepted.

Structure
REQ-036 A shared package gpio_bus_pkg SHALL hold:
- op codes;
- the FSM state enum;
- GPIO register offsets DATA=0x0, DIR=0x4, READ=0x8.
REQ-037 The poll gap/attempt timing SHALL be one sub-module, bus_master_down_counter (load, decrement, zero flag); all other logic is flat.

Verification
REQ-038 Write: op=00, addr=0x4, data=0xF → exactly one cycle with o_sel=1, o_we=1, o_addr=0x4, o_wdata=0xF; rsp_valid 2 cycles after accept, rsp_err=0.
REQ-039 Read: op=01, addr=0x8, i_rdata=0xA → one read cycle; rsp_data=0xA, rsp_err=0; with rsp_ready low 3 cycles, rsp_data stays stable and cmd_ready stays 0.
REQ-040 Poll success: mask=0x1, data=0x1, poll_gap=2, i_rdata bit0 rises before the 3rd read → exactly 3 read cycles spaced 3 cycles apart; rsp_err=0.
REQ-041 Poll timeout: poll_limit=4, never matching → exactly 4 reads; rsp_err=1, rsp_data=last i_rdata. Repeat with poll_limit=0 → exactly 1 read.
REQ-042 Reserved op 11 → no o_sel pulse; rsp_valid 1 cycle after accept with rsp_err=1.
REQ-043 Reset asserted during POLL_WAIT → o_sel, rsp_valid and cmd_ready state cleared immediately; after release cmd_ready=1 and no bus activity occurs.
